stream_mux_n: RTL and testbench

//   Parametrised N-channel, WIDTH-bit registered stream multiplexer; successor to the 2:1 bit mux.

---
 rtl/stream_mux_n.sv | 143 ++++++++++++++
 tb/tb_stream_mux_n.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_n
// Purpose  : Parametrised NCH-channel, WIDTH-bit valid/ready stream
//            multiplexer with a single registered output stage. Selects one
//            granted input channel per cycle and forwards its word with one
//            clock of latency. Full back-pressure, no loss or duplication.
// Config   : STREAM_MUX_RR_EN - when defined, sel is ignored and the grant
//            is produced by a round-robin pointer; otherwise grant = sel.
// Ports    : clk        - system clock (rising edge)
//            rst        - asynchronous active-high reset
//            in_data    - NCH*WIDTH packed channel data, ch i at [i*WIDTH +: WIDTH]
//            in_valid   - per-channel valid
//            in_ready   - per-channel ready (one-hot or zero)
//            sel        - channel select (fixed-select build only)
//            out_data   - registered output data
//            out_valid  - registered output valid
//            out_ready  - consumer ready
//            out_ch     - channel index that produced out_data
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_n #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    logic [WIDTH-1:0] r_out_data_q,  w_out_data_d;
    logic             r_out_valid_q, w_out_valid_d;
    logic [SELW-1:0]  r_out_ch_q,    w_out_ch_d;

    logic [SELW-1:0]  w_grant;
    logic             w_grant_ok;
    logic             w_load;
    logic             w_xfer_in;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_valid;

`ifdef STREAM_MUX_RR_EN
    logic [SELW-1:0]  r_ptr_q, w_ptr_d;
    logic             w_unused_sel;

    assign w_unused_sel = ^sel;

    // First valid channel at or after the pointer, wrapping past NCH-1.
    always_comb begin
        int idx;
        w_grant    = '0;
        w_grant_ok = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(r_ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!w_grant_ok && in_valid[idx]) begin
                w_grant_ok = 1'b1;
                w_grant    = SELW'(idx);
            end
        end
    end

    always_comb begin
        w_ptr_d = r_ptr_q;
        if (w_xfer_in)
            w_ptr_d = (w_grant == SELW'(NCH - 1)) ? '0 : w_grant + SELW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ptr_q <= '0;
        else     r_ptr_q <= w_ptr_d;
    end
`else
    assign w_grant = sel;

    // Only a non-power-of-two channel count can see an out-of-range select.
    if ((1 << SELW) == NCH) begin : g_sel_pow2
        assign w_grant_ok = 1'b1;
    end else begin : g_sel_npow2
        assign w_grant_ok = ({{(32 - SELW){1'b0}}, sel} < 32'(NCH));
    end
`endif

    // Decoded mux keeps out-of-range grants from indexing past the bus.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant == SELW'(i)) begin
                w_sel_data  = in_data[i*WIDTH +: WIDTH];
                w_sel_valid = in_valid[i];
            end
        end
    end

    // Gated by rst so nothing is accepted while the register is held clear.
    assign w_load    = !rst && (!r_out_valid_q || out_ready);
    assign w_xfer_in = w_load && w_grant_ok && w_sel_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++)
            in_ready[i] = w_load && w_grant_ok && (w_grant == SELW'(i));
    end

    always_comb begin
        w_out_data_d  = r_out_data_q;
        w_out_ch_d    = r_out_ch_q;
        w_out_valid_d = r_out_valid_q;
        if (w_load)
            w_out_valid_d = w_xfer_in;
        if (w_xfer_in) begin
            w_out_data_d = w_sel_data;
            w_out_ch_d   = w_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data_q  <= '0;
            r_out_ch_q    <= '0;
            r_out_valid_q <= 1'b0;
        end else begin
            r_out_data_q  <= w_out_data_d;
            r_out_ch_q    <= w_out_ch_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign out_data  = r_out_data_q;
    assign out_ch    = r_out_ch_q;
    assign out_valid = r_out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_n
// Purpose  : Directed self-checking bench for stream_mux_n (NCH=4 and NCH=3
//            instances). Round-robin checks run when STREAM_MUX_RR_EN is set,
//            select-driven checks otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_n;

    logic        clk;
    logic        rst;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_ch3;

    int n_cmp  = 0;
    int n_fail = 0;

    stream_mux_n #(.WIDTH(8), .NCH(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch)
    );

    stream_mux_n #(.WIDTH(8), .NCH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel(sel3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_ch(out_ch3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] v);
        in_data[ch*8 +: 8] = v;
    endtask

    initial begin
        rst        = 1'b1;
        in_data    = 32'h4433_2211;
        in_valid   = 4'b1111;
        sel        = 2'd2;
        out_ready  = 1'b1;
        in_data3   = 24'h33_2211;
        in_valid3  = 3'b111;
        sel3       = 2'd1;
        out_ready3 = 1'b1;

        // Reset state with every channel valid
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_ch",    32'(out_ch),    32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_in_ready3", 32'(in_ready3), 32'd0);
        tick();
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid  = 4'b0000;
        in_valid3 = 3'b000;

`ifdef STREAM_MUX_RR_EN
        // Round robin, all channels valid: 0,1,2,3,0
        in_data  = 32'h1312_1110;
        in_valid = 4'b1111;
        #1;
        check("rr_first_ready", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_all_ch",    32'(out_ch),    32'(k % 4));
            check("rr_all_data",  32'(out_data),  32'(8'h10 + (k % 4)));
            check("rr_all_valid", 32'(out_valid), 32'd1);
        end
        // Stall must not advance the pointer (next grant stays ch1)
        out_ready = 1'b0;
        #1;
        check("rr_stall_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check("rr_stall_ch", 32'(out_ch), 32'd0);
        out_ready = 1'b1;
        #1;
        check("rr_resume_ready", 32'(in_ready), 32'b0010);
        // Restart from pointer 0 with ch2 idle: 0,1,3,0
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        in_valid = 4'b1011;
        begin
            logic [1:0] exp_seq [4];
            exp_seq = '{2'd0, 2'd1, 2'd3, 2'd0};
            for (int k = 0; k < 4; k++) begin
                tick();
                check("rr_skip_ch",   32'(out_ch),   32'(exp_seq[k]));
                check("rr_skip_data", 32'(out_data), 32'(8'h10 + exp_seq[k]));
            end
        end
        in_valid = 4'b0000;
        tick();
        check("rr_idle_valid", 32'(out_valid), 32'd0);
`else
        // Single word from channel 2
        sel      = 2'd2;
        in_data  = 32'h33A5_1100;
        in_valid = 4'b0100;
        #1;
        check("sel2_in_ready", 32'(in_ready), 32'b0100);
        tick();
        check("sel2_out_valid", 32'(out_valid), 32'd1);
        check("sel2_out_data",  32'(out_data),  32'hA5);
        check("sel2_out_ch",    32'(out_ch),    32'd2);

        // Stall three cycles while sel/data churn
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            sel     = 2'(i);
            in_data = $urandom;
            #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("stall_out_data",  32'(out_data),  32'hA5);
            check("stall_out_ch",    32'(out_ch),    32'd2);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end

        // Release: drain and reload in the same edge
        out_ready = 1'b1;
        sel       = 2'd1;
        in_valid  = 4'b0010;
        in_data   = 32'hEE00_7700;
        set_ch(1, 8'h77);
        #1;
        check("reload_in_ready", 32'(in_ready), 32'b0010);
        tick();
        check("reload_out_data", 32'(out_data), 32'h77);
        check("reload_out_ch",   32'(out_ch),   32'd1);

        // Idle input: valid drops, data/ch hold
        in_valid = 4'b0000;
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_data",  32'(out_data),  32'h77);
        check("idle_out_ch",    32'(out_ch),    32'd1);

        // Streaming 0x01..0x10 from ch1, one per clock
        sel      = 2'd1;
        in_valid = 4'b1011;
        in_data  = 32'hCC00_00AA;
        for (int k = 1; k <= 16; k++) begin
            set_ch(1, 8'(k));
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data",  32'(out_data),  32'(k));
        end
        check("stream_ch", 32'(out_ch), 32'd1);

        // Reset mid-transfer discards the held word immediately
        set_ch(1, 8'h55);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  32'(out_data),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 4'b0000;

        // NCH=3: out-of-range select grants nothing
        sel3       = 2'd3;
        in_valid3  = 3'b111;
        in_data3   = 24'hC3_B2_A1;
        out_ready3 = 1'b1;
        #1;
        check("nch3_sel3_ready", 32'(in_ready3), 32'd0);
        tick();
        check("nch3_sel3_valid", 32'(out_valid3), 32'd0);
        sel3 = 2'd2;
        #1;
        check("nch3_sel2_ready", 32'(in_ready3), 32'b100);
        tick();
        check("nch3_sel2_data", 32'(out_data3), 32'hC3);
        check("nch3_sel2_ch",   32'(out_ch3),   32'd2);
        sel3 = 2'd3;
        tick();
        check("nch3_drain_valid", 32'(out_valid3), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
